// File: rtl/ui_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ui_uart_pkg
// Description : Shared types and helpers for the configurable UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package ui_uart_pkg;

    // Parity mode selected at elaboration.
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    // Receiver frame state.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } rx_state_e;

    // Rounded clock divider for one oversample tick.
    function automatic int calc_div(input int clock_rate, input int baud_rate,
                                    input int oversample);
        longint den;
        longint quo;
        den = longint'(baud_rate) * longint'(oversample);
        quo = (longint'(clock_rate) + (den / 2)) / den;
        return int'(quo);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ui_meta_harden.sv
`default_nettype none
// ============================================================================
// Module      : ui_meta_harden
// Description : Two-flop synchroniser for a single asynchronous input.
// Revision    : 1.0 - initial release
// ============================================================================
module ui_meta_harden #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_signal,
    output logic o_signal
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops resolve metastability on the pad input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_signal;
            r_sync <= r_meta;
        end
    end

    assign o_signal = r_sync;

endmodule
`default_nettype wire

// File: rtl/ui_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ui_uart_rx_fifo
// Description : Synchronous FIFO, first-word-fall-through output.
//               Push while full is accepted only with a simultaneous pop.
// Revision    : 1.0 - initial release
// ============================================================================
module ui_uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[c_AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/ui_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : ui_uart_rx_cfg
// Description : Parametrised UART receiver with majority-vote sampling,
//               parity/framing/break/overflow detection and output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ui_uart_rx_cfg
    import ui_uart_pkg::*;
#(
    parameter int CLOCK_RATE = 200_000_000,
    parameter int BAUD_RATE  = 9_600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frm_err,
    output logic                 par_err,
    output logic                 ovf_err,
    output logic                 brk_det
);

    localparam int c_DIV   = calc_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_OS_W  = $clog2(OVERSAMPLE);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);
    localparam logic [c_OS_W-1:0]  c_SMP_LO   = c_OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_OS_W-1:0]  c_SMP_MID  = c_OS_W'(OVERSAMPLE / 2);
    localparam logic [c_OS_W-1:0]  c_SMP_DEC  = c_OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [c_OS_W-1:0]  c_SMP_LAST = c_OS_W'(OVERSAMPLE - 1);
    localparam logic [3:0]         c_LAST_DAT = 4'(DATA_BITS - 1);
    localparam logic [3:0]         c_LAST_STP = 4'(STOP_BITS - 1);
    localparam parity_e            c_PAR_MODE = parity_e'(2'(PARITY));

    if (c_DIV < 1) begin : g_div_check
        $fatal(1, "ui_uart_rx_cfg: CLOCK_RATE too low for BAUD_RATE*OVERSAMPLE");
    end

    // ------------------------------------------------------------------------
    // Input synchroniser; the age pipe marks when its output reflects the pad
    // rather than the reset value, so a low line at reset release cannot arm.
    // ------------------------------------------------------------------------
    logic       w_rxd_s;
    logic [1:0] r_sync_age;

    ui_meta_harden #(.RESET_VAL(1'b1)) u_rxd_sync (
        .clk      (clk),
        .rst      (rst),
        .i_signal (rxd_i),
        .o_signal (w_rxd_s)
    );

    // Fill the age pipe after reset.
    always_ff @(posedge clk) begin
        if (rst) r_sync_age <= 2'b00;
        else     r_sync_age <= {r_sync_age[0], 1'b1};
    end

    // ------------------------------------------------------------------------
    // Free-running oversample tick generator.
    // ------------------------------------------------------------------------
    logic [c_DIV_W-1:0] r_div_cnt;
    logic               w_tick;

    assign w_tick = (r_div_cnt == c_DIV_LAST);

    // Divider counter wraps at DIV-1.
    always_ff @(posedge clk) begin
        if (rst)         r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + 1'b1;
    end

    // ------------------------------------------------------------------------
    // Receive FSM and sampling datapath.
    // ------------------------------------------------------------------------
    rx_state_e              r_state, w_state_nxt;
    logic [c_OS_W-1:0]      r_smp_cnt, w_smp_nxt;
    logic [3:0]             r_bit_idx, w_idx_nxt;
    logic [DATA_BITS-1:0]   r_shreg, w_shreg_nxt;
    logic                   r_smp_a, w_smp_a_nxt;
    logic                   r_smp_b, w_smp_b_nxt;
    logic                   r_par_bit, w_par_nxt;
    logic                   r_stop_bad, w_stop_bad_nxt;
    logic                   r_armed, w_armed_nxt;
    logic                   w_push, w_frm, w_par_e, w_brk;
    logic                   w_maj, w_at_dec, w_at_end;
    logic                   w_stop_any_bad, w_par_x, w_par_bad, w_brk_cond;
    logic                   r_frm_err, r_par_err, r_ovf_err, r_brk_det;
    logic                   w_fifo_full, w_fifo_empty, w_pop;

    assign w_maj          = (r_smp_a & r_smp_b) | (r_smp_a & w_rxd_s) | (r_smp_b & w_rxd_s);
    assign w_at_dec       = w_tick && (r_smp_cnt == c_SMP_DEC);
    assign w_at_end       = w_tick && (r_smp_cnt == c_SMP_LAST);
    assign w_stop_any_bad = r_stop_bad | ~w_maj;
    assign w_par_x        = (^r_shreg) ^ r_par_bit;
    assign w_par_bad      = (c_PAR_MODE == PAR_ODD)  ? ~w_par_x :
                            (c_PAR_MODE == PAR_EVEN) ?  w_par_x : 1'b0;
    // A break looks like an all-zero frame whose stop bit is also low.
    assign w_brk_cond     = (r_shreg == '0) & ~r_par_bit & w_stop_any_bad;

    // Next-state logic: sample capture, bit sequencing and stop evaluation.
    always_comb begin
        w_state_nxt    = r_state;
        w_smp_nxt      = r_smp_cnt;
        w_idx_nxt      = r_bit_idx;
        w_shreg_nxt    = r_shreg;
        w_smp_a_nxt    = r_smp_a;
        w_smp_b_nxt    = r_smp_b;
        w_par_nxt      = r_par_bit;
        w_stop_bad_nxt = r_stop_bad;
        w_armed_nxt    = r_armed;
        w_push         = 1'b0;
        w_frm          = 1'b0;
        w_par_e        = 1'b0;
        w_brk          = 1'b0;

        if (w_tick && (r_state != S_IDLE) && (r_state != S_BREAK)) begin
            w_smp_nxt = (r_smp_cnt == c_SMP_LAST) ? '0 : r_smp_cnt + 1'b1;
            if (r_smp_cnt == c_SMP_LO)  w_smp_a_nxt = w_rxd_s;
            if (r_smp_cnt == c_SMP_MID) w_smp_b_nxt = w_rxd_s;
        end

        case (r_state)
            S_IDLE: begin
                w_smp_nxt = '0;
                if (w_tick && r_sync_age[1] && w_rxd_s) w_armed_nxt = 1'b1;
                if (w_tick && r_armed && !w_rxd_s) begin
                    w_state_nxt    = S_START;
                    w_stop_bad_nxt = 1'b0;
                    w_par_nxt      = 1'b0;
                end
            end
            S_START: begin
                if (w_at_dec && w_maj) begin
                    w_state_nxt = S_IDLE;
                    w_smp_nxt   = '0;
                end else if (w_at_end) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_at_dec) w_shreg_nxt = {w_maj, r_shreg[DATA_BITS-1:1]};
                if (w_at_end) begin
                    if (r_bit_idx == c_LAST_DAT) begin
                        w_state_nxt = (c_PAR_MODE != PAR_NONE) ? S_PARITY : S_STOP;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_bit_idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_at_dec) w_par_nxt = w_maj;
                if (w_at_end) begin
                    w_state_nxt = S_STOP;
                    w_idx_nxt   = '0;
                end
            end
            S_STOP: begin
                if (w_at_dec) begin
                    if (r_bit_idx == c_LAST_STP) begin
                        // Evaluate at the last decision tick, not the bit end.
                        w_smp_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_state_nxt = S_IDLE;
                        if (w_brk_cond) begin
                            w_brk       = 1'b1;
                            w_state_nxt = S_BREAK;
                            w_armed_nxt = 1'b0;
                        end else if (w_stop_any_bad) begin
                            w_frm = 1'b1;
                        end else if (w_par_bad) begin
                            w_par_e = 1'b1;
                        end else begin
                            w_push = 1'b1;
                        end
                    end else begin
                        w_stop_bad_nxt = w_stop_any_bad;
                    end
                end else if (w_at_end) begin
                    w_idx_nxt = r_bit_idx + 1'b1;
                end
            end
            S_BREAK: begin
                w_smp_nxt = '0;
                if (w_tick && w_rxd_s) begin
                    w_state_nxt = S_IDLE;
                    w_armed_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_smp_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shreg    <= '0;
            r_smp_a    <= 1'b1;
            r_smp_b    <= 1'b1;
            r_par_bit  <= 1'b0;
            r_stop_bad <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_smp_cnt  <= w_smp_nxt;
            r_bit_idx  <= w_idx_nxt;
            r_shreg    <= w_shreg_nxt;
            r_smp_a    <= w_smp_a_nxt;
            r_smp_b    <= w_smp_b_nxt;
            r_par_bit  <= w_par_nxt;
            r_stop_bad <= w_stop_bad_nxt;
            r_armed    <= w_armed_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO and error pulses.
    // ------------------------------------------------------------------------
    assign m_valid = ~w_fifo_empty;
    assign w_pop   = m_valid & m_ready;

    ui_uart_rx_fifo #(
        .DATA_W (DATA_BITS),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (r_shreg),
        .i_pop   (w_pop),
        .o_data  (m_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Register error pulses so they line up with the FIFO update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frm_err <= 1'b0;
            r_par_err <= 1'b0;
            r_ovf_err <= 1'b0;
            r_brk_det <= 1'b0;
        end else begin
            r_frm_err <= w_frm;
            r_par_err <= w_par_e;
            r_ovf_err <= w_push & w_fifo_full & ~w_pop;
            r_brk_det <= w_brk;
        end
    end

    assign frm_err = r_frm_err;
    assign par_err = r_par_err;
    assign ovf_err = r_ovf_err;
    assign brk_det = r_brk_det;

endmodule
`default_nettype wire

// File: tb/tb_ui_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_ui_uart_rx_cfg
// Description : Self-checking bench for ui_uart_rx_cfg. Three instances:
//               a = 8N1 depth 4, b = 8E1, c = 5N2. DIV = 1, 16 clk per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ui_uart_rx_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] rxd_v;
    logic [2:0] rdy_v;
    logic [2:0] val_v, frm_v, par_v, ovf_v, brk_v;
    logic [7:0] data_a, data_b;
    logic [4:0] data_c;

    ui_uart_rx_cfg #(.CLOCK_RATE(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                     .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .rxd_i(rxd_v[0]), .m_data(data_a), .m_valid(val_v[0]),
        .m_ready(rdy_v[0]), .frm_err(frm_v[0]), .par_err(par_v[0]), .ovf_err(ovf_v[0]),
        .brk_det(brk_v[0]));

    ui_uart_rx_cfg #(.CLOCK_RATE(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                     .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .rxd_i(rxd_v[1]), .m_data(data_b), .m_valid(val_v[1]),
        .m_ready(rdy_v[1]), .frm_err(frm_v[1]), .par_err(par_v[1]), .ovf_err(ovf_v[1]),
        .brk_det(brk_v[1]));

    ui_uart_rx_cfg #(.CLOCK_RATE(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                     .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
        .clk(clk), .rst(rst), .rxd_i(rxd_v[2]), .m_data(data_c), .m_valid(val_v[2]),
        .m_ready(rdy_v[2]), .frm_err(frm_v[2]), .par_err(par_v[2]), .ovf_err(ovf_v[2]),
        .brk_det(brk_v[2]));

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int frm_cnt[3] = '{0, 0, 0};
    int par_cnt[3] = '{0, 0, 0};
    int ovf_cnt[3] = '{0, 0, 0};
    int brk_cnt[3] = '{0, 0, 0};
    int word_cnt[3] = '{0, 0, 0};
    logic [8:0] last_word[3];
    int multi_cnt = 0;
    int va_rises = 0;
    int va_hi = 0;
    int va_last_rise = 0;
    logic va_prev = 1'b0;

    function automatic logic [8:0] get_data(input int i);
        case (i)
            0:       return {1'b0, data_a};
            1:       return {1'b0, data_b};
            default: return {4'b0, data_c};
        endcase
    endfunction

    function automatic int err_sum(input int i);
        return frm_cnt[i] + par_cnt[i] + ovf_cnt[i] + brk_cnt[i];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse, pop and valid-timing monitor, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (frm_v[i]) frm_cnt[i]++;
            if (par_v[i]) par_cnt[i]++;
            if (ovf_v[i]) ovf_cnt[i]++;
            if (brk_v[i]) brk_cnt[i]++;
            if ((int'(frm_v[i]) + int'(par_v[i]) + int'(ovf_v[i]) + int'(brk_v[i])) > 1)
                multi_cnt++;
            if (val_v[i] && rdy_v[i]) begin
                word_cnt[i]++;
                last_word[i] = get_data(i);
            end
        end
        if (val_v[0]) va_hi++;
        if (val_v[0] && !va_prev) begin
            va_rises++;
            va_last_rise = cyc;
        end
        va_prev = val_v[0];
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame, 16 clk per bit; glitch_bit inverts clk 9 of that bit.
    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input bit has_par, input bit par_bit, input int nstop,
                              input bit stop_val, input int glitch_bit, input int gap);
        int nb;
        logic v;
        nb = 1 + nbits + (has_par ? 1 : 0) + nstop;
        for (int b = 0; b < nb; b++) begin
            if (b == 0)                          v = 1'b0;
            else if (b <= nbits)                 v = data[b-1];
            else if (has_par && b == nbits + 1)  v = par_bit;
            else                                 v = stop_val;
            for (int c = 0; c < 16; c++) begin
                rxd_v[sel] = (b == glitch_bit && c == 9) ? ~v : v;
                step(1);
            end
        end
        rxd_v[sel] = 1'b1;
        step(gap);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_val;
        int         glitch_bit;
        int         exp_words;
        logic [7:0] exp_data;
        int         exp_frm;
        int         exp_brk;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int w0, e0, f0, b0, p0, o0, r0, h0, c0, tot0;

        vecs[0] = '{8'h00, 1'b1, -1, 1, 8'h00, 0, 0};
        vecs[1] = '{8'hFF, 1'b1, -1, 1, 8'hFF, 0, 0};
        vecs[2] = '{8'h3C, 1'b0, -1, 0, 8'h00, 1, 0};
        vecs[3] = '{8'h00, 1'b0, -1, 0, 8'h00, 0, 1};
        vecs[4] = '{8'h5A, 1'b1,  3, 1, 8'h5A, 0, 0};
        vecs[5] = '{8'h81, 1'b1, -1, 1, 8'h81, 0, 0};

        rst   = 1'b1;
        rxd_v = 3'b111;
        rdy_v = 3'b111;
        step(4);
        check("reset_valid", int'(val_v), 0);
        check("reset_flags", int'(frm_v | par_v | ovf_v | brk_v), 0);
        rst = 1'b0;
        step(8);

        // 8N1 0xA5: valid for one clk, rising 157 clk after the start edge
        // (2 sync + 1 detect + 9*16 bits + decision tick 9 of stop + 1 push).
        r0 = va_rises; h0 = va_hi; e0 = err_sum(0); w0 = word_cnt[0];
        c0 = cyc;
        send_frame(0, 9'h0A5, 8, 0, 0, 1, 1'b1, -1, 24);
        check("t1_rises", va_rises - r0, 1);
        check("t1_latency", va_last_rise - c0, 157);
        check("t1_width", va_hi - h0, 1);
        check("t1_words", word_cnt[0] - w0, 1);
        check("t1_data", int'(last_word[0]), 'hA5);
        check("t1_noerr", err_sum(0) - e0, 0);

        // Even parity: 0x03 p=0 accepted, p=1 rejected.
        w0 = word_cnt[1]; p0 = par_cnt[1];
        send_frame(1, 9'h003, 8, 1, 1'b0, 1, 1'b1, -1, 24);
        check("t2_good_word", word_cnt[1] - w0, 1);
        check("t2_good_data", int'(last_word[1]), 'h03);
        check("t2_good_par", par_cnt[1] - p0, 0);
        send_frame(1, 9'h003, 8, 1, 1'b1, 1, 1'b1, -1, 24);
        check("t2_bad_word", word_cnt[1] - w0, 1);
        check("t2_bad_par", par_cnt[1] - p0, 1);

        // Short low glitch is rejected silently.
        w0 = word_cnt[0]; e0 = err_sum(0);
        rxd_v[0] = 1'b0;
        step(4);
        rxd_v[0] = 1'b1;
        step(40);
        check("t3_glitch_words", word_cnt[0] - w0, 0);
        check("t3_glitch_flags", err_sum(0) - e0, 0);

        // Table of 8N1 frames on instance a.
        for (int i = 0; i < 6; i++) begin
            w0 = word_cnt[0]; f0 = frm_cnt[0]; b0 = brk_cnt[0];
            p0 = par_cnt[0]; o0 = ovf_cnt[0];
            send_frame(0, {1'b0, vecs[i].data}, 8, 0, 0, 1, vecs[i].stop_val,
                       vecs[i].glitch_bit, 24);
            check($sformatf("vec%0d_words", i), word_cnt[0] - w0, vecs[i].exp_words);
            if (vecs[i].exp_words == 1)
                check($sformatf("vec%0d_data", i), int'(last_word[0]), int'(vecs[i].exp_data));
            check($sformatf("vec%0d_frm", i), frm_cnt[0] - f0, vecs[i].exp_frm);
            check($sformatf("vec%0d_brk", i), brk_cnt[0] - b0, vecs[i].exp_brk);
            check($sformatf("vec%0d_other", i), (par_cnt[0] - p0) + (ovf_cnt[0] - o0), 0);
        end

        // FIFO fill and overflow with the consumer stalled.
        rdy_v[0] = 1'b0;
        o0 = ovf_cnt[0]; w0 = word_cnt[0];
        for (int i = 1; i <= 4; i++) send_frame(0, 9'(i), 8, 0, 0, 1, 1'b1, -1, 8);
        check("t4_valid_full", int'(val_v[0]), 1);
        check("t4_head_stable", int'(data_a), 'h01);
        check("t4_no_ovf_yet", ovf_cnt[0] - o0, 0);
        send_frame(0, 9'h005, 8, 0, 0, 1, 1'b1, -1, 8);
        check("t4_ovf", ovf_cnt[0] - o0, 1);
        check("t4_no_pop", word_cnt[0] - w0, 0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t4_pop%0d_valid", i), int'(val_v[0]), 1);
            check($sformatf("t4_pop%0d_data", i), int'(data_a), i);
            rdy_v[0] = 1'b1;
            step(1);
            rdy_v[0] = 1'b0;
        end
        check("t4_empty", int'(val_v[0]), 0);
        rdy_v[0] = 1'b1;
        step(4);

        // Break: line low for 3 frame times.
        b0 = brk_cnt[0]; f0 = frm_cnt[0]; w0 = word_cnt[0];
        rxd_v[0] = 1'b0;
        step(480);
        rxd_v[0] = 1'b1;
        step(40);
        check("t5_brk", brk_cnt[0] - b0, 1);
        check("t5_no_frm", frm_cnt[0] - f0, 0);
        check("t5_no_word", word_cnt[0] - w0, 0);
        send_frame(0, 9'h07E, 8, 0, 0, 1, 1'b1, -1, 24);
        check("t5_after_words", word_cnt[0] - w0, 1);
        check("t5_after_data", int'(last_word[0]), 'h7E);

        // Reset during data bit 4 of a 5N2 frame; then 0x33 -> 0x13.
        tot0 = err_sum(0) + err_sum(1) + err_sum(2);
        w0 = word_cnt[0] + word_cnt[1] + word_cnt[2];
        fork
            send_frame(2, 9'h0FF, 5, 0, 0, 2, 1'b1, -1, 40);
            begin
                step(16 * 5 + 8);
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
        join
        check("t6_rst_words", word_cnt[0] + word_cnt[1] + word_cnt[2] - w0, 0);
        check("t6_rst_flags", err_sum(0) + err_sum(1) + err_sum(2) - tot0, 0);
        w0 = word_cnt[2]; e0 = err_sum(2);
        send_frame(2, 9'h033, 5, 0, 0, 2, 1'b1, -1, 24);
        check("t6_words", word_cnt[2] - w0, 1);
        check("t6_data", int'(last_word[2]), 'h13);
        check("t6_flags", err_sum(2) - e0, 0);

        check("exclusive_pulses", multi_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ui_uart_rx_cfg.md
Name: ui_uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver in the ui block.
- Frame format set at elaboration: 5–9 data bits, none/odd/even parity, 1 or 2 stop bits, configurable oversampling.
- 3-sample majority-vote bit sampling and start-bit glitch rejection.
- Parity, framing, break and overflow detection.
- Received words buffered in a small FIFO with a valid/ready output handshake toward the ui command parser.

Parameters:
- CLOCK_RATE, 200_000_000, clk frequency in Hz.
- BAUD_RATE, 9_600, line bit rate in bps.
- OVERSAMPLE, 16, sample ticks per bit; even, 8..32.
- DATA_BITS, 8, data bits per frame; 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous to clk, active high.
- rxd_i  in  1  RS232 RXD pin, asynchronous, directly from pad.
- m_data  out  DATA_BITS  received word, LSB = first bit on line; valid when m_valid is high.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts m_data this cycle.
- frm_err  out  1  1-cycle pulse: stop bit sampled low (non-break).
- par_err  out  1  1-cycle pulse: parity mismatch.
- ovf_err  out  1  1-cycle pulse: good word dropped because FIFO full.
- brk_det  out  1  1-cycle pulse: break condition detected.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, tick/sample counters 0. m_data is don't-care while m_valid = 0.
- Input sync: rxd_i goes through a 2-FF synchroniser, reset value 1.
- Tick generator:
  - DIV = round(CLOCK_RATE / (BAUD_RATE*OVERSAMPLE)); DIV ≥ 1 is checked at elaboration (fatal otherwise).
  - Counter 0..DIV-1 emits a 1-cycle tick at DIV-1.
  - Free-running; not resynchronised to frames.
- Sampling: within each bit, ticks are counted 0..OVERSAMPLE-1. Bit value = majority of samples at ticks OVERSAMPLE/2-1, /2 and /2+1; the decision is made at tick OVERSAMPLE/2+1.
- FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, plus BREAK.
  - IDLE:
    - Armed only after rxd has been sampled high on at least one tick since reset or since BREAK ended.
    - A low sample on a tick -> START, bit tick counter = 0.
  - START:
    - Majority 1 -> glitch; return to IDLE, no flags.
    - Majority 0 -> continue to the end of the bit period, then enter DATA.
  - DATA: shift DATA_BITS bits LSB first, index 0..DATA_BITS-1.
  - PARITY (only when PARITY ≠ 0): odd requires XOR(data, p) = 1; even requires XOR(data, p) = 0.
  - STOP: each of the STOP_BITS bits is majority-sampled. Evaluation happens at the decision tick of the last stop bit; the FSM does not wait for that bit to end.
- STOP evaluation, in priority order:
  1. Data all zero, parity bit 0 or absent, and any stop sample 0 -> brk_det pulse, no push, go to BREAK.
  2. Any stop sample 0 -> frm_err pulse, no push, go to IDLE.
  3. Parity mismatch -> par_err pulse, no push, go to IDLE.
  4. Otherwise push the word. If the FIFO is full and there is no simultaneous pop, pulse ovf_err and leave the FIFO unchanged.
  - When a framing error and a parity error occur in the same frame, only frm_err pulses.
- BREAK: wait for rxd sampled high on a tick, then go to IDLE (armed).
- Latency: push takes effect in the cycle after the decision tick, so m_valid rises one clk after that tick when the FIFO was empty.
- FIFO rules:
  - Pop when m_valid & m_ready.
  - Simultaneous push and pop is legal at any occupancy, including full; the push is accepted.
  - m_data stays stable while m_valid & !m_ready.
  - m_ready while empty has no effect.
- Error pulses fire exactly once per frame and are mutually exclusive in any cycle.
- Reset mid-frame: the frame is abandoned, the FIFO is emptied and no pulses are emitted. If rxd is low when reset releases, it does not count as a start bit (IDLE arming rule).

Decomposition:
- Package ui_uart_pkg holds:
  - parity_e (NONE, ODD, EVEN);
  - rx_state_e (IDLE, START, DATA, PARITY, STOP, BREAK);
  - function calc_div(clock_rate, baud_rate, oversample).
- Instantiate the existing ui_meta_harden for rxd_i.
- One sub-module, ui_uart_rx_fifo: parametrised DATA_W/DEPTH synchronous FIFO with push/pop/full/empty and first-word-fall-through output.
- Tick generator, majority vote and FSM live in the top level.

Test Plan:
Bench defaults: CLOCK_RATE = 16_000_000, BAUD_RATE = 1_000_000, OVERSAMPLE = 16 -> DIV = 1, 16 clk per bit.
1. 8N1, send 0xA5 with m_ready = 1 -> m_valid high for 1 cycle with m_data = 0xA5, one clk after the stop decision tick; no error pulses.
2. PARITY = 2 (even), send 0x03 with p = 0, then 0x03 with p = 1 -> first word pushed; second gives a par_err pulse and is not pushed.
3. Hold rxd low for 4 clk, then high -> no push, no flags, FSM back in IDLE. Then send 0x5A with a single-clk high glitch at the mid-sample of bit 2 -> m_data = 0x5A.
4. FIFO_DEPTH = 4, m_ready = 0, send 0x01..0x05 -> 4 entries held, ovf_err pulses on 0x05. Then pop 4 words -> 0x01, 0x02, 0x03, 0x04 in order, then m_valid = 0.
5. Hold rxd low for 3 frame times, then high -> a single brk_det pulse, no frm_err, no push. Then send 0x7E -> received correctly.
6. Assert rst for 1 cycle during bit 4 of 0xFF -> no push and no pulses. A following 0x33 is received with DATA_BITS = 5 (m_data = 0x13) and STOP_BITS = 2.
